// File: rtl/i2c_reg_target.sv
// I2C target register bank emulating the display controller.
// Pointer byte then data writes; reads auto-increment from the pointer.
module i2c_reg_target #(
    parameter logic [6:0] DEV_ADDR = 7'h20,
    parameter int          ADDR_W   = 4,
    parameter int          FILT     = 3
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] loc_addr,
    output logic [7:0]        loc_data,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = $clog2(FILT + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_A, PTR, ACK_P, WDAT, ACK_W, RDAT, ACK_R
    } state_t;

    logic [1:0] w_pin;
    logic [1:0] w_flt;
    logic [1:0] r_prv;

    assign w_pin = {sda_in, scl_in};

    // bit 0 = SCL, bit 1 = SDA
    for (genvar g = 0; g < 2; g++) begin : g_flt
        logic          r_s1;
        logic          r_s2;
        logic          r_f;
        logic [CW-1:0] r_cnt;

        always_ff @(posedge CLOCK_50 or posedge rst) begin
            if (rst) begin
                r_s1  <= 1'b1;
                r_s2  <= 1'b1;
                r_f   <= 1'b1;
                r_cnt <= '0;
            end else begin
                r_s1 <= w_pin[g];
                r_s2 <= r_s1;
                if (r_s2 == r_f) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(FILT - 1)) begin
                    r_f   <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_flt[g] = r_f;
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) r_prv <= 2'b11;
        else     r_prv <= w_flt;
    end

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_sda;

    assign w_sda      = w_flt[1];
    assign w_scl_rise = w_flt[0] & ~r_prv[0];
    assign w_scl_fall = ~w_flt[0] & r_prv[0];
    assign w_start    = w_flt[0] & r_prv[0] & r_prv[1] & ~w_flt[1];
    assign w_stop     = w_flt[0] & r_prv[0] & ~r_prv[1] & w_flt[1];

    state_t            r_state;
    logic [3:0]        r_bcnt;
    logic [7:0]        r_shift;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_ackd;
    logic [7:0]        r_bank [DEPTH];

    logic [7:0] w_byte;
    logic [7:0] w_rd_byte;
    logic       w_last;

    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_rd_byte = r_bank[r_ptr];
    assign w_last    = (r_bcnt == 4'd7);
    assign loc_data  = r_bank[loc_addr];

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_ptr   <= '0;
            r_ackd  <= 1'b0;
            sda_oe  <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_bank[ADDR_W'(i)] <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (w_stop) begin
                r_state <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                r_ackd  <= 1'b0;
            end else if (w_start) begin
                r_state <= ADDR;
                r_bcnt  <= '0;
                sda_oe  <= 1'b0;
                r_ackd  <= 1'b0;
            end else if (w_scl_rise) begin
                unique case (r_state)
                    ADDR: begin
                        r_shift <= w_byte;
                        r_bcnt  <= w_last ? 4'd0 : r_bcnt + 1'b1;
                        if (w_last && w_byte[7:1] == DEV_ADDR) begin
                            r_state <= ACK_A;
                            busy    <= 1'b1;
                        end else if (w_last) begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    PTR: begin
                        r_shift <= w_byte;
                        r_bcnt  <= w_last ? 4'd0 : r_bcnt + 1'b1;
                        if (w_last) begin
                            r_ptr   <= w_byte[ADDR_W-1:0];
                            r_state <= ACK_P;
                        end
                    end
                    WDAT: begin
                        r_shift <= w_byte;
                        r_bcnt  <= w_last ? 4'd0 : r_bcnt + 1'b1;
                        if (w_last) r_state <= ACK_W;
                    end
                    ACK_A, ACK_P: r_ackd <= 1'b1;
                    ACK_W: begin
                        r_ackd         <= 1'b1;
                        r_bank[r_ptr]  <= r_shift;
                        wr_stb         <= 1'b1;
                        wr_addr        <= r_ptr;
                        wr_data        <= r_shift;
                        r_ptr          <= r_ptr + 1'b1;
                    end
                    RDAT: begin
                        r_shift <= {r_shift[6:0], 1'b0};
                        r_bcnt  <= r_bcnt + 1'b1;
                    end
                    ACK_R: begin
                        if (w_sda) r_state <= IDLE;
                        else       r_ackd  <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (w_scl_fall) begin
                unique case (r_state)
                    ACK_A, ACK_P, ACK_W: begin
                        if (!r_ackd) begin
                            sda_oe <= 1'b1;
                        end else begin
                            r_ackd <= 1'b0;
                            r_bcnt <= '0;
                            if (r_state == ACK_A && r_shift[0]) begin
                                r_shift <= w_rd_byte;
                                sda_oe  <= ~w_rd_byte[7];
                                r_state <= RDAT;
                            end else begin
                                sda_oe  <= 1'b0;
                                r_state <= (r_state == ACK_A) ? PTR : WDAT;
                            end
                        end
                    end
                    RDAT: begin
                        if (r_bcnt == 4'd8) begin
                            sda_oe  <= 1'b0;
                            r_bcnt  <= '0;
                            r_ptr   <= r_ptr + 1'b1;
                            r_state <= ACK_R;
                        end else begin
                            sda_oe <= ~r_shift[7];
                        end
                    end
                    ACK_R: begin
                        if (r_ackd) begin
                            r_ackd  <= 1'b0;
                            r_shift <= w_rd_byte;
                            sda_oe  <= ~w_rd_byte[7];
                            r_state <= RDAT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master with an
// open-drain bus model, vector table plus hand-written corner cases.
module tb_i2c_reg_target;

    logic       CLOCK_50 = 1'b0;
    logic       rst      = 1'b0;
    logic       scl      = 1'b1;
    logic       m_sda    = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] loc_addr = 4'd0;
    logic [7:0] loc_data;
    logic       busy;

    assign sda_in = m_sda & ~sda_oe;

    always #10 CLOCK_50 = ~CLOCK_50;

    i2c_reg_target #(.DEV_ADDR(7'h20), .ADDR_W(4), .FILT(3)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .scl_in   (scl),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .loc_addr (loc_addr),
        .loc_data (loc_data),
        .busy     (busy)
    );

    typedef enum logic [2:0] {OP_S, OP_SR, OP_P, OP_W, OP_RA, OP_RN} op_t;
    typedef struct {
        op_t        op;
        logic [7:0] d;
        logic [7:0] exp;
        logic       busy;
    } vec_t;

    vec_t        tbl[$];
    logic [11:0] log_q[$];
    int          oe_cnt = 0;
    int          n_vec  = 0;
    int          n_bad  = 0;

    always @(negedge CLOCK_50) begin
        if (wr_stb) log_q.push_back({wr_addr, wr_data});
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic chk(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; scl = 1'b1; cyc(20);
        m_sda = 1'b0; cyc(20);
        scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        cyc(10); m_sda = 1'b1; cyc(10);
        scl = 1'b1; cyc(20);
        m_sda = 1'b0; cyc(20);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(10); m_sda = 1'b0; cyc(10);
        scl = 1'b1; cyc(20);
        m_sda = 1'b1; cyc(20);
    endtask

    task automatic wr_bit(input logic b);
        cyc(10); m_sda = b; cyc(10);
        scl = 1'b1; cyc(20);
        scl = 1'b0;
    endtask

    task automatic rd_bit(output logic b);
        cyc(10); m_sda = 1'b1; cyc(10);
        scl = 1'b1; cyc(10);
        b = sda_in; cyc(10);
        scl = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(b);
        ack = ~b;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(nack);
    endtask

    task automatic chk_loc(input logic [3:0] a, input logic [7:0] exp);
        loc_addr = a;
        #1;
        chk($sformatf("loc[%0d]", a), {4'h0, loc_data}, {4'h0, exp});
    endtask

    task automatic add(input op_t op, input logic [7:0] d,
                       input logic [7:0] exp, input logic bz);
        vec_t v;
        v.op = op; v.d = d; v.exp = exp; v.busy = bz;
        tbl.push_back(v);
    endtask

    initial begin
        logic        ack;
        logic [7:0]  rb;
        int          n0;
        int          oe0;
        logic [11:0] exp_log [5];

        // write 0x03: AA, 55
        add(OP_S,  8'h00, 8'h00, 1'b0);
        add(OP_W,  8'h40, 8'h01, 1'b1);
        add(OP_W,  8'h03, 8'h01, 1'b1);
        add(OP_W,  8'hAA, 8'h01, 1'b1);
        add(OP_W,  8'h55, 8'h01, 1'b1);
        add(OP_P,  8'h00, 8'h00, 1'b0);
        // pointer write then repeated-start read
        add(OP_S,  8'h00, 8'h00, 1'b0);
        add(OP_W,  8'h40, 8'h01, 1'b1);
        add(OP_W,  8'h03, 8'h01, 1'b1);
        add(OP_SR, 8'h00, 8'h00, 1'b1);
        add(OP_W,  8'h41, 8'h01, 1'b1);
        add(OP_RA, 8'h00, 8'hAA, 1'b1);
        add(OP_RN, 8'h00, 8'h55, 1'b1);
        add(OP_P,  8'h00, 8'h00, 1'b0);
        // pointer wrap 15 -> 0 -> 1
        add(OP_S,  8'h00, 8'h00, 1'b0);
        add(OP_W,  8'h40, 8'h01, 1'b1);
        add(OP_W,  8'h0F, 8'h01, 1'b1);
        add(OP_W,  8'h01, 8'h01, 1'b1);
        add(OP_W,  8'h02, 8'h01, 1'b1);
        add(OP_W,  8'h03, 8'h01, 1'b1);
        add(OP_P,  8'h00, 8'h00, 1'b0);

        exp_log = '{12'h3AA, 12'h455, 12'hF01, 12'h002, 12'h103};

        #2 rst = 1'b1;
        cyc(4);
        chk("rst sda_oe",  {11'h0, sda_oe}, 12'h0);
        chk("rst wr_stb",  {11'h0, wr_stb}, 12'h0);
        chk("rst wr_addr", {8'h0, wr_addr}, 12'h0);
        chk("rst wr_data", {4'h0, wr_data}, 12'h0);
        chk("rst busy",    {11'h0, busy},   12'h0);
        chk_loc(4'd0, 8'h00);
        chk_loc(4'd15, 8'h00);
        rst = 1'b0;
        cyc(30);

        // wrong address: nothing acked, never drives
        oe0 = oe_cnt;
        i2c_start();
        wr_byte(8'h42, ack);
        chk("badaddr ack", {11'h0, ack}, 12'h0);
        chk("badaddr busy", {11'h0, busy}, 12'h0);
        wr_byte(8'h00, ack);
        chk("badaddr ptr ack", {11'h0, ack}, 12'h0);
        wr_byte(8'h11, ack);
        chk("badaddr dat ack", {11'h0, ack}, 12'h0);
        i2c_stop();
        chk("badaddr oe cycles", 12'(oe_cnt - oe0), 12'h0);
        chk("badaddr stb", 12'(log_q.size()), 12'h0);
        chk_loc(4'd0, 8'h00);

        foreach (tbl[i]) begin
            unique case (tbl[i].op)
                OP_S:  i2c_start();
                OP_SR: i2c_rstart();
                OP_P:  i2c_stop();
                OP_W: begin
                    wr_byte(tbl[i].d, ack);
                    chk($sformatf("v%0d ack", i), {11'h0, ack},
                        {4'h0, tbl[i].exp});
                end
                OP_RA, OP_RN: begin
                    rd_byte(tbl[i].op == OP_RN, rb);
                    chk($sformatf("v%0d rdata", i), {4'h0, rb},
                        {4'h0, tbl[i].exp});
                end
                default: ;
            endcase
            chk($sformatf("v%0d busy", i), {11'h0, busy},
                {11'h0, tbl[i].busy});
        end

        chk("stb count", 12'(log_q.size()), 12'd5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("stb%0d", k),
                (k < log_q.size()) ? log_q[k] : 12'hFFF, exp_log[k]);
        chk_loc(4'd3, 8'hAA);
        chk_loc(4'd4, 8'h55);
        chk_loc(4'd15, 8'h01);
        chk_loc(4'd0, 8'h02);
        chk_loc(4'd1, 8'h03);
        chk_loc(4'd2, 8'h00);

        // STOP in the middle of a data byte
        n0 = log_q.size();
        i2c_start();
        wr_byte(8'h40, ack);
        chk("abort addr ack", {11'h0, ack}, 12'h1);
        wr_byte(8'h05, ack);
        chk("abort ptr ack", {11'h0, ack}, 12'h1);
        wr_bit(1'b1); wr_bit(1'b0); wr_bit(1'b1); wr_bit(1'b1);
        i2c_stop();
        chk("abort busy", {11'h0, busy}, 12'h0);
        chk("abort no stb", 12'(log_q.size() - n0), 12'h0);
        chk_loc(4'd5, 8'h00);
        i2c_start();
        wr_byte(8'h40, ack);
        chk("after abort ack", {11'h0, ack}, 12'h1);
        chk("after abort busy", {11'h0, busy}, 12'h1);
        i2c_stop();

        // reset while driving a 0 data bit (bank[0] = 0x02)
        i2c_start();
        wr_byte(8'h40, ack);
        wr_byte(8'h00, ack);
        i2c_rstart();
        wr_byte(8'h41, ack);
        chk("rd6 addr ack", {11'h0, ack}, 12'h1);
        cyc(12);
        chk("rd6 driving", {11'h0, sda_oe}, 12'h1);
        rst = 1'b1;
        #1;
        chk("async rst oe", {11'h0, sda_oe}, 12'h0);
        chk("async rst busy", {11'h0, busy}, 12'h0);
        cyc(3);
        rst = 1'b0;
        i2c_stop();
        for (int k = 0; k < 16; k++) chk_loc(4'(k), 8'h00);
        i2c_start();
        wr_byte(8'h41, ack);
        chk("post rst ack", {11'h0, ack}, 12'h1);
        rd_byte(1'b1, rb);
        chk("post rst rdata", {4'h0, rb}, 12'h0);
        i2c_stop();
        chk("post rst busy", {11'h0, busy}, 12'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
